// File: rtl/nabp_pkg.sv
// Shared definitions for the NABP mapper/shifter datapath: address widths,
// default image size and the shifter control-state encoding.
package nabp_pkg;

  localparam int unsigned kSLength     = 9;
  localparam int unsigned kAngleLength = 8;
  localparam int unsigned kImageSize   = 256;

  typedef enum logic [2:0] {
    ST_READY = 3'd0,
    ST_KICK  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/nabp_shifter_delay.sv
// Aligns the line-buffer read strobe with its returned data: the strobe is
// delayed RAM_LATENCY cycles and the sample is held between strobes.
module nabp_shifter_delay #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [RAM_LATENCY-1:0] vld_q, vld_d;
  logic [DATA_WIDTH-1:0]  hold_q, hold_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      hold_q <= '0;
    end else begin
      vld_q  <= vld_d;
      hold_q <= hold_d;
    end
  end

  // Read data arrives in the same cycle as the delayed strobe, so the live
  // sample is forwarded and only the held copy is registered.
  always_comb begin
    vld_d   = RAM_LATENCY'({vld_q, rd_en_i});
    valid_o = vld_q[RAM_LATENCY-1];
    hold_d  = valid_o ? rd_data_i : hold_q;
    data_o  = valid_o ? rd_data_i : hold_q;
  end

endmodule

// File: rtl/nabp_shifter.sv
// Shifter side of the mapper/shifter handshake: kicks the mapper, issues
// IMAGE_SIZE shift/read strobes, drains the line buffer and signals done.
// Optional NABP_SHIFTER_STALL_EN adds pe_ready back-pressure on the strobes.
module nabp_shifter
  import nabp_pkg::*;
#(
  parameter int unsigned IMAGE_SIZE  = kImageSize,
  parameter int unsigned S_LENGTH    = kSLength,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned RAM_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sc_kick,
  output logic                  sc_ready,
  output logic                  sh_kick,
  input  logic                  sh_ack,
  output logic                  sh_shift_en,
  output logic                  sh_done,
  input  logic [S_LENGTH-1:0]   fr_s_val,
  output logic [S_LENGTH-1:0]   lb_addr,
  output logic                  lb_rd_en,
  input  logic [DATA_WIDTH-1:0] lb_data,
`ifdef NABP_SHIFTER_STALL_EN
  input  logic                  pe_ready,
`endif
  output logic                  pe_shift_en,
  output logic [DATA_WIDTH-1:0] pe_data
);

  localparam int unsigned CNT_W = $clog2(IMAGE_SIZE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMAGE_SIZE - 1);
  localparam logic [1:0] DRN_LAST = 2'(RAM_LATENCY - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       drn_q, drn_d;
  logic             pe_go;
  logic             shift;

`ifdef NABP_SHIFTER_STALL_EN
  assign pe_go = pe_ready;
`else
  assign pe_go = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_READY;
      cnt_q   <= '0;
      drn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    unique case (state_q)
      ST_READY: if (sc_kick) state_d = ST_KICK;
      ST_KICK:  if (sh_ack) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (!sh_ack) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (drn_q == DRN_LAST) begin
          state_d = ST_DONE;
          drn_d   = '0;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
      ST_DONE:  state_d = ST_READY;
      default:  state_d = ST_READY;
    endcase
    // The ack cycle in KICK already carries the first strobe, so the count
    // and the exit to DRAIN are driven by the strobe rather than the state.
    if (shift) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        state_d = ST_DRAIN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sc_ready    = (state_q == ST_READY);
    sh_kick     = (state_q == ST_KICK);
    sh_done     = (state_q == ST_DONE);
    shift       = ((state_q == ST_KICK) || (state_q == ST_SHIFT)) && sh_ack && pe_go;
    sh_shift_en = shift;
    lb_rd_en    = shift;
    lb_addr     = shift ? fr_s_val : '0;
  end

  nabp_shifter_delay #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_LATENCY(RAM_LATENCY)
  ) u_delay (
    .clk      (clk),
    .reset    (reset),
    .rd_en_i  (lb_rd_en),
    .rd_data_i(lb_data),
    .valid_o  (pe_shift_en),
    .data_o   (pe_data)
  );

endmodule

// File: tb/tb_nabp_shifter.sv
// Bench for nabp_shifter: two DUTs (RAM_LATENCY 1 and 2) share the control
// stimulus, each with its own mapper and line-buffer model.
module tb_nabp_shifter;

  localparam int N   = 4;
  localparam int SL  = 9;
  localparam int DW  = 16;
  localparam int LOG = 256;

  logic clk = 1'b0;
  logic reset, sc_kick, pe_ready;
  logic sc_ready[2], sh_kick[2], sh_ack[2], sh_shift_en[2], sh_done[2];
  logic lb_rd_en[2], pe_shift_en[2];
  logic [SL-1:0] fr_s_val[2], lb_addr[2];
  logic [DW-1:0] lb_data[2], pe_data[2];

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;
  int ack_dly;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nabp_shifter #(.IMAGE_SIZE(N), .S_LENGTH(SL), .DATA_WIDTH(DW), .RAM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .sc_kick(sc_kick), .sc_ready(sc_ready[0]),
    .sh_kick(sh_kick[0]), .sh_ack(sh_ack[0]), .sh_shift_en(sh_shift_en[0]),
    .sh_done(sh_done[0]), .fr_s_val(fr_s_val[0]), .lb_addr(lb_addr[0]),
    .lb_rd_en(lb_rd_en[0]), .lb_data(lb_data[0]),
`ifdef NABP_SHIFTER_STALL_EN
    .pe_ready(pe_ready),
`endif
    .pe_shift_en(pe_shift_en[0]), .pe_data(pe_data[0]));

  nabp_shifter #(.IMAGE_SIZE(N), .S_LENGTH(SL), .DATA_WIDTH(DW), .RAM_LATENCY(2)) dut_l2 (
    .clk(clk), .reset(reset), .sc_kick(sc_kick), .sc_ready(sc_ready[1]),
    .sh_kick(sh_kick[1]), .sh_ack(sh_ack[1]), .sh_shift_en(sh_shift_en[1]),
    .sh_done(sh_done[1]), .fr_s_val(fr_s_val[1]), .lb_addr(lb_addr[1]),
    .lb_rd_en(lb_rd_en[1]), .lb_data(lb_data[1]),
`ifdef NABP_SHIFTER_STALL_EN
    .pe_ready(pe_ready),
`endif
    .pe_shift_en(pe_shift_en[1]), .pe_data(pe_data[1]));

  // Mapper model: acks ack_dly cycles after the kick, steps through s_tab.
  logic [DW-1:0] mem [512];
  logic [SL-1:0] s_tab [8];
  logic [3:0]    kc [2];
  logic [2:0]    idx [2];
  logic [DW-1:0] r1 [2], r2 [2];

  assign fr_s_val[0] = sh_ack[0] ? s_tab[idx[0]] : '0;
  assign fr_s_val[1] = sh_ack[1] ? s_tab[idx[1]] : '0;
  assign lb_data[0]  = r1[0];
  assign lb_data[1]  = r2[1];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        sh_ack[i] <= 1'b0;
        kc[i]     <= '0;
        idx[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sh_done[i]) begin
          sh_ack[i] <= 1'b0;
          kc[i]     <= '0;
          idx[i]    <= '0;
        end else begin
          if (sh_kick[i] && !sh_ack[i]) begin
            kc[i] <= kc[i] + 4'd1;
            if (int'(kc[i]) + 1 >= ack_dly) sh_ack[i] <= 1'b1;
          end
          if (sh_shift_en[i]) idx[i] <= idx[i] + 3'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      r1[i] <= mem[lb_addr[i]];
      r2[i] <= r1[i];
    end
  end

  // Event logs, appended only by this monitor.
  int shk_n[2] = '{default: 0};
  int sh_n[2]  = '{default: 0};
  int pe_n[2]  = '{default: 0};
  int dn_n[2]  = '{default: 0};
  int shk_c[2][LOG];
  int sh_c[2][LOG];
  int pe_c[2][LOG];
  int dn_c[2][LOG];
  logic [SL-1:0] sh_a[2][LOG];
  logic [DW-1:0] pe_d[2][LOG];
  logic rdy_h[2][1024];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rdy_h[i][cyc % 1024] <= sc_ready[i];
      if (sh_kick[i] && shk_n[i] < LOG) begin
        shk_c[i][shk_n[i]] <= cyc;
        shk_n[i] <= shk_n[i] + 1;
      end
      if (sh_shift_en[i] && sh_n[i] < LOG) begin
        sh_c[i][sh_n[i]] <= cyc;
        sh_a[i][sh_n[i]] <= lb_addr[i];
        sh_n[i] <= sh_n[i] + 1;
      end
      if (pe_shift_en[i] && pe_n[i] < LOG) begin
        pe_c[i][pe_n[i]] <= cyc;
        pe_d[i][pe_n[i]] <= pe_data[i];
        pe_n[i] <= pe_n[i] + 1;
      end
      if (sh_done[i] && dn_n[i] < LOG) begin
        dn_c[i][dn_n[i]] <= cyc;
        dn_n[i] <= dn_n[i] + 1;
      end
    end
  end

  // One line: kick at cycle k, mapper ack delay d, optional 3-cycle pe_ready
  // stall after the first shift, optional stray kicks during SHIFT and DONE.
  task automatic test_line(input string name, input int d, input bit stall, input bit poke);
    int k, f, last, dn, n, ec;
    int b_shk[2], b_sh[2], b_pe[2], b_dn[2];
    @(posedge clk); #1;
    ack_dly = d;
    for (int j = 0; j < 8; j++) s_tab[j] = (j < N) ? SL'($urandom_range(511, 1)) : '0;
    for (int i = 0; i < 2; i++) begin
      b_shk[i] = shk_n[i]; b_sh[i] = sh_n[i]; b_pe[i] = pe_n[i]; b_dn[i] = dn_n[i];
    end
    k = cyc;
    f = k + 1 + d;
    sc_kick = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      sc_kick  = poke && (cyc == f + 1 || cyc == k + d + N + 2);
      pe_ready = !(stall && cyc >= f + 1 && cyc <= f + 3);
    end
    sc_kick  = 1'b0;
    pe_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      n = shk_n[i] - b_shk[i];
      chk_cnt++;
      if (n !== d + 1 || shk_c[i][b_shk[i]] !== k + 1)
        $display("FAIL %s L%0d sh_kick: %0d cycles from %0d, want %0d from %0d",
                 name, i + 1, n, shk_c[i][b_shk[i]], d + 1, k + 1);
      else pass_cnt++;
      n = sh_n[i] - b_sh[i];
      chk_cnt++;
      if (n !== N) $display("FAIL %s L%0d shift count: got %0d want %0d", name, i + 1, n, N);
      else pass_cnt++;
      last = 0;
      for (int j = 0; j < N; j++) begin
        ec = f + j + ((stall && j > 0) ? 3 : 0);
        last = ec;
        chk_cnt++;
        if (sh_c[i][b_sh[i] + j] !== ec || sh_a[i][b_sh[i] + j] !== s_tab[j])
          $display("FAIL %s L%0d shift%0d: cyc %0d addr %0d, want cyc %0d addr %0d", name, i + 1, j,
                   sh_c[i][b_sh[i] + j], sh_a[i][b_sh[i] + j], ec, s_tab[j]);
        else pass_cnt++;
        chk_cnt++;
        if (pe_c[i][b_pe[i] + j] !== ec + i + 1 || pe_d[i][b_pe[i] + j] !== mem[s_tab[j]])
          $display("FAIL %s L%0d pe%0d: cyc %0d data %h, want cyc %0d data %h", name, i + 1, j,
                   pe_c[i][b_pe[i] + j], pe_d[i][b_pe[i] + j], ec + i + 1, mem[s_tab[j]]);
        else pass_cnt++;
      end
      n = pe_n[i] - b_pe[i];
      chk_cnt++;
      if (n !== N) $display("FAIL %s L%0d pe count: got %0d want %0d", name, i + 1, n, N);
      else pass_cnt++;
      dn = last + (i + 1) + 1;
      n = dn_n[i] - b_dn[i];
      chk_cnt++;
      if (n !== 1 || dn_c[i][b_dn[i]] !== dn)
        $display("FAIL %s L%0d sh_done: %0d pulses first at %0d, want 1 at %0d",
                 name, i + 1, n, dn_c[i][b_dn[i]], dn);
      else pass_cnt++;
      chk_cnt++;
      if (rdy_h[i][dn % 1024] !== 1'b0 || rdy_h[i][(dn + 1) % 1024] !== 1'b1)
        $display("FAIL %s L%0d sc_ready around done: %b%b want 01", name, i + 1,
                 rdy_h[i][dn % 1024], rdy_h[i][(dn + 1) % 1024]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (sc_ready[i] !== 1'b1 || {sh_kick[i], sh_shift_en[i], sh_done[i], lb_rd_en[i],
                                   pe_shift_en[i], lb_addr[i], pe_data[i]} !== '0)
        $display("FAIL reset L%0d outputs: ready %b others %b, want ready 1 others 0", i + 1,
                 sc_ready[i], {sh_kick[i], sh_shift_en[i], sh_done[i], lb_rd_en[i],
                               pe_shift_en[i], lb_addr[i], pe_data[i]});
      else pass_cnt++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    test_line("basic", 1, 1'b0, 1'b0);
  endtask

  task automatic test_ack_delay();
    test_line("ack_delay", 5, 1'b0, 1'b0);
  endtask

  task automatic test_ignore_kicks();
    test_line("ignore_kicks", 1, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midline();
    int k, b_dn[2];
    @(posedge clk); #1;
    ack_dly = 1;
    for (int j = 0; j < 8; j++) s_tab[j] = (j < N) ? SL'($urandom_range(511, 1)) : '0;
    k = cyc;
    sc_kick = 1'b1;
    @(posedge clk); #1;
    sc_kick = 1'b0;
    while (cyc < k + 3) begin @(posedge clk); #1; end
    for (int i = 0; i < 2; i++) b_dn[i] = dn_n[i];
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (sc_ready[i] !== 1'b1 || {sh_kick[i], sh_shift_en[i], sh_done[i], lb_rd_en[i],
                                   pe_shift_en[i], lb_addr[i], pe_data[i]} !== '0)
        $display("FAIL midline_reset L%0d outputs: ready %b others %b, want ready 1 others 0",
                 i + 1, sc_ready[i], {sh_kick[i], sh_shift_en[i], sh_done[i], lb_rd_en[i],
                                      pe_shift_en[i], lb_addr[i], pe_data[i]});
      else pass_cnt++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      chk_cnt++;
      if (dn_n[i] !== b_dn[i])
        $display("FAIL midline_reset L%0d sh_done count: got %0d want %0d", i + 1, dn_n[i], b_dn[i]);
      else pass_cnt++;
    end
    test_line("after_reset", 1, 1'b0, 1'b0);
  endtask

`ifdef NABP_SHIFTER_STALL_EN
  task automatic test_stall();
    test_line("stall", 1, 1'b1, 1'b0);
    test_line("stall_delay", 3, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_random();
    bit st;
    for (int r = 0; r < 5; r++) begin
      st = 1'b0;
`ifdef NABP_SHIFTER_STALL_EN
      st = 1'($urandom_range(1, 0));
`endif
      test_line("random", int'($urandom_range(6, 1)), st, 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    reset    = 1'b1;
    sc_kick  = 1'b0;
    pe_ready = 1'b1;
    ack_dly  = 1;
    for (int a = 0; a < 512; a++) mem[a] = DW'($urandom);
    mem[0] = '0;
    for (int j = 0; j < 8; j++) s_tab[j] = '0;
    test_reset();
    test_basic();
    test_ack_delay();
    test_ignore_kicks();
    test_reset_midline();
`ifdef NABP_SHIFTER_STALL_EN
    test_stall();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
